// File: rtl/cachepool_boot_ctrl.sv
// Multi-cluster boot sequencer: writes a boot address to each enabled cluster,
// wakes the successfully booted ones and collects their end-of-computing flags.
module cachepool_boot_ctrl #(
    parameter int unsigned          NumClusters   = 4,
    parameter int unsigned          NumCores      = 4,
    parameter int unsigned          AddrWidth     = 32,
    parameter int unsigned          DataWidth     = 32,
    parameter logic [AddrWidth-1:0] BootRegBase   = AddrWidth'(32'h4000_0000),
    parameter logic [AddrWidth-1:0] ClusterStride = AddrWidth'(32'h0010_0000),
    parameter int unsigned          StartDelay    = 1000,
    parameter int unsigned          TimeoutCycles = 1 << 20
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            start_i,
    input  logic [31:0]                     entry_point_i,
    input  logic [NumClusters-1:0]          cluster_mask_i,
    output logic                            req_valid_o,
    input  logic                            req_ready_i,
    output logic [AddrWidth-1:0]            req_addr_o,
    output logic [DataWidth-1:0]            req_data_o,
    output logic                            req_write_o,
    output logic [DataWidth/8-1:0]          req_strb_o,
    input  logic                            rsp_valid_i,
    input  logic                            rsp_error_i,
    output logic                            rsp_ready_o,
    output logic [NumClusters*NumCores-1:0] debug_req_o,
    input  logic [NumClusters-1:0]          eoc_i,
    output logic                            busy_o,
    output logic                            done_o,
    output logic [NumClusters-1:0]          eoc_seen_o,
    output logic [NumClusters-1:0]          boot_err_o,
    output logic                            timeout_o
);

    localparam int unsigned IdxW = (NumClusters > 1) ? $clog2(NumClusters) : 1;
    localparam logic [31:0] DelayLoad   = 32'(StartDelay - 1);
    localparam logic [31:0] TimeoutLoad = 32'(TimeoutCycles - 1);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] DELAY    = 3'd1;
    localparam logic [2:0] WRITE    = 3'd2;
    localparam logic [2:0] RESP     = 3'd3;
    localparam logic [2:0] WAKE     = 3'd4;
    localparam logic [2:0] WAIT_EOC = 3'd5;
    localparam logic [2:0] DONE     = 3'd6;

    logic [2:0]             state_q, state_d;
    logic [NumClusters-1:0] mask_q, mask_d;
    logic [IdxW-1:0]        idx_q, idx_d;
    logic [31:0]            cnt_q, cnt_d;
    logic [AddrWidth-1:0]   req_addr_q, req_addr_d;
    logic [DataWidth-1:0]   req_data_q, req_data_d;
    logic [NumClusters-1:0] eoc_seen_q, eoc_seen_d;
    logic [NumClusters-1:0] boot_err_q, boot_err_d;
    logic                   timeout_q, timeout_d;

    logic [NumClusters-1:0] expected;
    logic [IdxW-1:0]        first_idx, next_idx;
    logic                   has_next;

    function automatic logic [AddrWidth-1:0] addr_of(input logic [IdxW-1:0] idx);
        return BootRegBase + AddrWidth'(idx) * ClusterStride;
    endfunction

    assign expected = mask_q & ~boot_err_q;

    // Descending scan so the final assignment lands on the lowest qualifying cluster.
    always_comb begin
        first_idx = '0;
        next_idx  = '0;
        has_next  = 1'b0;
        for (int c = int'(NumClusters) - 1; c >= 0; c--) begin
            if (mask_q[c]) begin
                first_idx = IdxW'(c);
            end
            if (mask_q[c] && (c > int'(idx_q))) begin
                next_idx = IdxW'(c);
                has_next = 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        mask_d     = mask_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        req_addr_d = req_addr_q;
        req_data_d = req_data_q;
        eoc_seen_d = eoc_seen_q;
        boot_err_d = boot_err_q;
        timeout_d  = timeout_q;

        if (state_q == WAKE || state_q == WAIT_EOC || state_q == DONE) begin
            eoc_seen_d = eoc_seen_q | (eoc_i & expected);
        end

        case (state_q)
            IDLE, DONE: begin
                if (start_i) begin
                    mask_d     = cluster_mask_i;
                    req_data_d = DataWidth'(entry_point_i);
                    eoc_seen_d = '0;
                    boot_err_d = '0;
                    timeout_d  = 1'b0;
                    cnt_d      = DelayLoad;
                    state_d    = (cluster_mask_i == '0) ? DONE : DELAY;
                end
            end
            DELAY: begin
                if (cnt_q == '0) begin
                    idx_d      = first_idx;
                    req_addr_d = addr_of(first_idx);
                    state_d    = WRITE;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            WRITE: begin
                if (req_ready_i) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_valid_i) begin
                    boot_err_d = boot_err_q | (NumClusters'(rsp_error_i) << idx_q);
                    if (has_next) begin
                        idx_d      = next_idx;
                        req_addr_d = addr_of(next_idx);
                        state_d    = WRITE;
                    end else begin
                        state_d = WAKE;
                    end
                end
            end
            WAKE: begin
                cnt_d   = TimeoutLoad;
                state_d = WAIT_EOC;
            end
            WAIT_EOC: begin
                // A completing EOC in the last counted cycle takes priority over timeout.
                if ((eoc_seen_d & expected) == expected) begin
                    state_d = DONE;
                end else if (cnt_q == '0) begin
                    timeout_d = 1'b1;
                    state_d   = DONE;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            mask_q     <= '0;
            idx_q      <= '0;
            cnt_q      <= '0;
            req_addr_q <= '0;
            req_data_q <= '0;
            eoc_seen_q <= '0;
            boot_err_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            mask_q     <= mask_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            req_addr_q <= req_addr_d;
            req_data_q <= req_data_d;
            eoc_seen_q <= eoc_seen_d;
            boot_err_q <= boot_err_d;
            timeout_q  <= timeout_d;
        end
    end

    always_comb begin
        debug_req_o = '0;
        if (state_q == WAKE) begin
            for (int c = 0; c < int'(NumClusters); c++) begin
                debug_req_o[c*NumCores +: NumCores] = {NumCores{expected[c]}};
            end
        end
    end

    assign req_valid_o = (state_q == WRITE);
    assign req_write_o = (state_q == WRITE);
    assign rsp_ready_o = (state_q == RESP);
    assign req_addr_o  = req_addr_q;
    assign req_data_o  = req_data_q;
    assign req_strb_o  = '1;
    assign busy_o      = (state_q != IDLE) && (state_q != DONE);
    assign done_o      = (state_q == DONE);
    assign eoc_seen_o  = eoc_seen_q;
    assign boot_err_o  = boot_err_q;
    assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_cachepool_boot_ctrl.sv
// Directed testbench for cachepool_boot_ctrl with four clusters of four cores,
// a short start delay and a 16-cycle EOC timeout.
module tb_cachepool_boot_ctrl;

    localparam int SD = 4;
    localparam int TC = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] entry = '0;
    logic [3:0]  mask = '0;
    logic        req_valid_o;
    logic        req_ready = 1'b0;
    logic [31:0] req_addr_o;
    logic [31:0] req_data_o;
    logic        req_write_o;
    logic [3:0]  req_strb_o;
    logic        rsp_valid = 1'b0;
    logic        rsp_error = 1'b0;
    logic        rsp_ready_o;
    logic [15:0] debug_req_o;
    logic [3:0]  eoc = '0;
    logic        busy_o;
    logic        done_o;
    logic [3:0]  eoc_seen_o;
    logic [3:0]  boot_err_o;
    logic        timeout_o;

    int tests_run = 0;
    int tests_failed = 0;

    cachepool_boot_ctrl #(
        .NumClusters  (4),
        .NumCores     (4),
        .AddrWidth    (32),
        .DataWidth    (32),
        .BootRegBase  (32'h4000_0000),
        .ClusterStride(32'h0010_0000),
        .StartDelay   (SD),
        .TimeoutCycles(TC)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .start_i       (start),
        .entry_point_i (entry),
        .cluster_mask_i(mask),
        .req_valid_o   (req_valid_o),
        .req_ready_i   (req_ready),
        .req_addr_o    (req_addr_o),
        .req_data_o    (req_data_o),
        .req_write_o   (req_write_o),
        .req_strb_o    (req_strb_o),
        .rsp_valid_i   (rsp_valid),
        .rsp_error_i   (rsp_error),
        .rsp_ready_o   (rsp_ready_o),
        .debug_req_o   (debug_req_o),
        .eoc_i         (eoc),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .eoc_seen_o    (eoc_seen_o),
        .boot_err_o    (boot_err_o),
        .timeout_o     (timeout_o)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 ns after each rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [31:0] e, input logic [3:0] m);
        entry = e;
        mask  = m;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_write(output int n);
        n = 0;
        while (req_valid_o !== 1'b1 && n < 50) begin
            step();
            n++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({req_valid_o, rsp_ready_o, busy_o, done_o, timeout_o} !== 5'b0 || debug_req_o !== 16'h0 ||
            eoc_seen_o !== 4'h0 || boot_err_o !== 4'h0 || req_addr_o !== 32'h0 || req_data_o !== 32'h0) begin
            tests_failed++;
            $display("[TB] FAIL reset_values: valid=%b rdy=%b busy=%b done=%b to=%b dbg=%h seen=%b err=%b addr=%h data=%h, required all zero",
                     req_valid_o, rsp_ready_o, busy_o, done_o, timeout_o, debug_req_o, eoc_seen_o, boot_err_o, req_addr_o, req_data_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        tests_run++;
        if (busy_o !== 1'b0 || done_o !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL idle_after_reset: busy=%b done=%b, required 0 0", busy_o, done_o);
        end
    endtask

    task automatic test_basic_boot();
        int n;
        logic [31:0] exp_addr;
        req_ready = 1'b1;
        rsp_valid = 1'b1;
        do_start(32'h8000_3000, 4'b1111);
        tests_run++;
        if (busy_o !== 1'b1 || req_valid_o !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL basic_busy: busy=%b valid=%b, required 1 0", busy_o, req_valid_o);
        end
        wait_write(n);
        tests_run++;
        if (n !== SD) begin
            tests_failed++;
            $display("[TB] FAIL basic_start_latency: %0d cycles, required %0d", n, SD);
        end
        for (int k = 0; k < 4; k++) begin
            exp_addr = 32'h4000_0000 + k * 32'h0010_0000;
            tests_run++;
            if (req_valid_o !== 1'b1 || req_write_o !== 1'b1 || req_addr_o !== exp_addr ||
                req_data_o !== 32'h8000_3000 || req_strb_o !== 4'hF) begin
                tests_failed++;
                $display("[TB] FAIL basic_write%0d: valid=%b wr=%b addr=%h data=%h strb=%h, required 1 1 %h 80003000 f",
                         k, req_valid_o, req_write_o, req_addr_o, req_data_o, req_strb_o, exp_addr);
            end
            step();
            tests_run++;
            if (rsp_ready_o !== 1'b1 || req_valid_o !== 1'b0 || debug_req_o !== 16'h0) begin
                tests_failed++;
                $display("[TB] FAIL basic_resp%0d: rdy=%b valid=%b dbg=%h, required 1 0 0000",
                         k, rsp_ready_o, req_valid_o, debug_req_o);
            end
            step();
        end
        tests_run++;
        if (debug_req_o !== 16'hFFFF) begin
            tests_failed++;
            $display("[TB] FAIL basic_wake: dbg=%h, required ffff", debug_req_o);
        end
        step();
        tests_run++;
        if (debug_req_o !== 16'h0) begin
            tests_failed++;
            $display("[TB] FAIL basic_wake_pulse_width: dbg=%h, required 0000", debug_req_o);
        end
        eoc = 4'b0001;
        step();
        eoc = 4'b0011;
        step();
        eoc = 4'b0111;
        step();
        tests_run++;
        if (done_o !== 1'b0 || eoc_seen_o !== 4'b0111) begin
            tests_failed++;
            $display("[TB] FAIL basic_partial_eoc: done=%b seen=%b, required 0 0111", done_o, eoc_seen_o);
        end
        eoc = 4'b1111;
        step();
        tests_run++;
        if (done_o !== 1'b1 || busy_o !== 1'b0 || eoc_seen_o !== 4'b1111 || timeout_o !== 1'b0 || boot_err_o !== 4'b0) begin
            tests_failed++;
            $display("[TB] FAIL basic_done: done=%b busy=%b seen=%b to=%b err=%b, required 1 0 1111 0 0000",
                     done_o, busy_o, eoc_seen_o, timeout_o, boot_err_o);
        end
        eoc = 4'b0000;
    endtask

    task automatic test_sparse_backpressure();
        int n;
        logic [31:0] exp_addr;
        req_ready = 1'b0;
        rsp_valid = 1'b1;
        do_start(32'h1234_5678, 4'b1010);
        wait_write(n);
        tests_run++;
        if (n !== SD) begin
            tests_failed++;
            $display("[TB] FAIL sparse_start_latency: %0d cycles, required %0d", n, SD);
        end
        for (int j = 0; j < 2; j++) begin
            exp_addr = (j == 0) ? 32'h4010_0000 : 32'h4030_0000;
            for (int i = 0; i < 6; i++) begin
                tests_run++;
                if (req_valid_o !== 1'b1 || req_addr_o !== exp_addr || req_data_o !== 32'h1234_5678 || req_strb_o !== 4'hF) begin
                    tests_failed++;
                    $display("[TB] FAIL sparse_stall%0d_%0d: valid=%b addr=%h data=%h strb=%h, required 1 %h 12345678 f",
                             j, i, req_valid_o, req_addr_o, req_data_o, req_strb_o, exp_addr);
                end
                if (i < 5) step();
            end
            req_ready = 1'b1;
            step();
            req_ready = 1'b0;
            tests_run++;
            if (rsp_ready_o !== 1'b1) begin
                tests_failed++;
                $display("[TB] FAIL sparse_resp%0d: rdy=%b, required 1", j, rsp_ready_o);
            end
            step();
        end
        tests_run++;
        if (debug_req_o !== 16'hF0F0) begin
            tests_failed++;
            $display("[TB] FAIL sparse_wake: dbg=%h, required f0f0", debug_req_o);
        end
        step();
        eoc = 4'b1111;
        step();
        tests_run++;
        if (done_o !== 1'b1 || eoc_seen_o !== 4'b1010 || boot_err_o !== 4'b0) begin
            tests_failed++;
            $display("[TB] FAIL sparse_done: done=%b seen=%b err=%b, required 1 1010 0000", done_o, eoc_seen_o, boot_err_o);
        end
        eoc = 4'b0000;
    endtask

    task automatic test_error_skip();
        int n;
        req_ready = 1'b1;
        rsp_valid = 1'b1;
        do_start(32'h0000_2000, 4'b1111);
        wait_write(n);
        for (int k = 0; k < 4; k++) begin
            step();
            rsp_error = (k == 2);
            step();
            rsp_error = 1'b0;
        end
        tests_run++;
        if (debug_req_o !== 16'hF0FF || boot_err_o !== 4'b0100) begin
            tests_failed++;
            $display("[TB] FAIL error_wake: dbg=%h err=%b, required f0ff 0100", debug_req_o, boot_err_o);
        end
        step();
        eoc = 4'b1011;
        step();
        tests_run++;
        if (done_o !== 1'b1 || eoc_seen_o !== 4'b1011 || timeout_o !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL error_done: done=%b seen=%b to=%b, required 1 1011 0", done_o, eoc_seen_o, timeout_o);
        end
        eoc = 4'b0000;
    endtask

    task automatic test_timeout();
        int n;
        req_ready = 1'b1;
        rsp_valid = 1'b1;
        do_start(32'h0000_3000, 4'b1111);
        wait_write(n);
        for (int k = 0; k < 4; k++) begin
            step();
            step();
        end
        eoc = 4'b0111;
        n = 0;
        while (done_o !== 1'b1 && n < 100) begin
            step();
            n++;
        end
        tests_run++;
        if (n !== TC + 1) begin
            tests_failed++;
            $display("[TB] FAIL timeout_latency: %0d cycles after wake, required %0d", n, TC + 1);
        end
        tests_run++;
        if (timeout_o !== 1'b1 || eoc_seen_o !== 4'b0111 || done_o !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL timeout_flags: to=%b seen=%b done=%b, required 1 0111 1", timeout_o, eoc_seen_o, done_o);
        end
        eoc = 4'b0000;
    endtask

    task automatic test_mask_zero_restart();
        int n;
        int valid_hits;
        do_start(32'hFFFF_0000, 4'b0000);
        tests_run++;
        if (done_o !== 1'b1 || busy_o !== 1'b0 || timeout_o !== 1'b0 || eoc_seen_o !== 4'b0 || req_valid_o !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL mask_zero_done: done=%b busy=%b to=%b seen=%b valid=%b, required 1 0 0 0000 0",
                     done_o, busy_o, timeout_o, eoc_seen_o, req_valid_o);
        end
        valid_hits = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (req_valid_o !== 1'b0 || debug_req_o !== 16'h0) valid_hits++;
        end
        tests_run++;
        if (valid_hits !== 0) begin
            tests_failed++;
            $display("[TB] FAIL mask_zero_quiet: %0d active cycles, required 0", valid_hits);
        end
        req_ready = 1'b1;
        rsp_valid = 1'b1;
        do_start(32'hA5A5_0000, 4'b0001);
        tests_run++;
        if (busy_o !== 1'b1 || done_o !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL restart_busy: busy=%b done=%b, required 1 0", busy_o, done_o);
        end
        wait_write(n);
        tests_run++;
        if (n !== SD || req_addr_o !== 32'h4000_0000 || req_data_o !== 32'hA5A5_0000) begin
            tests_failed++;
            $display("[TB] FAIL restart_write: lat=%0d addr=%h data=%h, required %0d 40000000 a5a50000",
                     n, req_addr_o, req_data_o, SD);
        end
        step();
        step();
        tests_run++;
        if (debug_req_o !== 16'h000F) begin
            tests_failed++;
            $display("[TB] FAIL restart_wake: dbg=%h, required 000f", debug_req_o);
        end
        step();
        eoc = 4'b0001;
        step();
        tests_run++;
        if (done_o !== 1'b1 || eoc_seen_o !== 4'b0001) begin
            tests_failed++;
            $display("[TB] FAIL restart_done: done=%b seen=%b, required 1 0001", done_o, eoc_seen_o);
        end
        eoc = 4'b0000;
    endtask

    task automatic test_reset_mid_write();
        int n;
        logic [31:0] exp_addr;
        req_ready = 1'b0;
        rsp_valid = 1'b1;
        do_start(32'hDEAD_BEEF, 4'b1111);
        wait_write(n);
        tests_run++;
        if (req_valid_o !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL midreset_pre: valid=%b, required 1", req_valid_o);
        end
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({req_valid_o, rsp_ready_o, busy_o, done_o, timeout_o} !== 5'b0 || debug_req_o !== 16'h0 ||
            req_addr_o !== 32'h0 || req_data_o !== 32'h0 || eoc_seen_o !== 4'h0 || boot_err_o !== 4'h0) begin
            tests_failed++;
            $display("[TB] FAIL midreset_async: valid=%b rdy=%b busy=%b done=%b addr=%h data=%h, required all zero",
                     req_valid_o, rsp_ready_o, busy_o, done_o, req_addr_o, req_data_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        req_ready = 1'b1;
        do_start(32'h0000_1000, 4'b0011);
        wait_write(n);
        for (int k = 0; k < 2; k++) begin
            exp_addr = 32'h4000_0000 + k * 32'h0010_0000;
            tests_run++;
            if (req_valid_o !== 1'b1 || req_addr_o !== exp_addr || req_data_o !== 32'h0000_1000) begin
                tests_failed++;
                $display("[TB] FAIL midreset_write%0d: valid=%b addr=%h data=%h, required 1 %h 00001000",
                         k, req_valid_o, req_addr_o, req_data_o, exp_addr);
            end
            step();
            step();
        end
        tests_run++;
        if (debug_req_o !== 16'h00FF) begin
            tests_failed++;
            $display("[TB] FAIL midreset_wake: dbg=%h, required 00ff", debug_req_o);
        end
        step();
        eoc = 4'b0011;
        step();
        tests_run++;
        if (done_o !== 1'b1 || eoc_seen_o !== 4'b0011 || timeout_o !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL midreset_done: done=%b seen=%b to=%b, required 1 0011 0", done_o, eoc_seen_o, timeout_o);
        end
        eoc = 4'b0000;
    endtask

    initial begin
        test_reset();
        test_basic_boot();
        test_sparse_backpressure();
        test_error_skip();
        test_timeout();
        test_mask_zero_restart();
        test_reset_mid_write();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/cachepool_boot_ctrl.md
# cachepool_boot_ctrl

Synthesizable multi-cluster boot sequencer for CachePool SoCs. It sits between the SoC control plane and `NumClusters` CachePool clusters:
- for each enabled cluster, writes a boot address into that cluster's peripheral boot-control register over a reqrsp write port;
- wakes every successfully booted cluster's cores with a one-cycle `debug_req` pulse;
- collects each cluster's end-of-computing signal, applying a global timeout.

It generalises the single-cluster boot/wake/EOC sequence to N clusters, with masking, error capture and timeout.

## Interface
Parameters:
- NumClusters, 4, number of clusters sequenced (1..16)
- NumCores, 4, cores per cluster (width of each cluster's debug_req slice)
- AddrWidth, 32, reqrsp address width
- DataWidth, 32, reqrsp data width (≥32)
- BootRegBase, 32'h4000_0000, boot-control register address of cluster 0
- ClusterStride, 32'h0010_0000, address step between clusters' boot registers
- StartDelay, 1000, idle cycles between start and the first write (≥1)
- TimeoutCycles, 1<<20, maximum cycles in WAIT_EOC (≥1)

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- start_i  in  1  start pulse; sampled only in IDLE or DONE
- entry_point_i  in  32  boot address, captured on accepted start
- cluster_mask_i  in  NumClusters  enabled clusters, captured on accepted start
- req_valid_o  out  1  reqrsp q_valid
- req_ready_i  in  1  reqrsp q_ready
- req_addr_o  out  AddrWidth  BootRegBase + idx*ClusterStride
- req_data_o  out  DataWidth  captured entry point, zero-extended
- req_write_o  out  1  1 while req_valid_o is high
- req_strb_o  out  DataWidth/8  all ones
- rsp_valid_i  in  1  reqrsp p_valid
- rsp_error_i  in  1  response error flag
- rsp_ready_o  out  1  reqrsp p_ready
- debug_req_o  out  NumClusters*NumCores  wake pulse; cluster c owns bits [c*NumCores +: NumCores]
- eoc_i  in  NumClusters  per-cluster end-of-computing level
- busy_o  out  1  FSM is not in IDLE or DONE
- done_o  out  1  sequence finished; held high in DONE
- eoc_seen_o  out  NumClusters  sticky per-cluster EOC capture
- boot_err_o  out  NumClusters  sticky: boot write returned an error
- timeout_o  out  1  sticky: WAIT_EOC expired

## Operation
- States: IDLE, DELAY, WRITE, RESP, WAKE, WAIT_EOC, DONE.
- IDLE/DONE, start_i=1:
  - capture entry_point_i and cluster_mask_i;
  - clear eoc_seen_o, boot_err_o and timeout_o;
  - load the delay counter with StartDelay-1;
  - go to DELAY. start_i in any other state is ignored.
- Captured mask == 0: go from IDLE/DONE directly to DONE. No writes, no wake.
- DELAY: count down to 0, then go to WRITE with idx = lowest enabled cluster.
- WRITE:
  - req_valid_o=1 with addr, data and strb stable until req_ready_i;
  - on handshake go to RESP.
- RESP:
  - rsp_ready_o=1;
  - on rsp_valid_i: boot_err_o[idx] |= rsp_error_i;
  - if another enabled cluster exists above idx, set idx to it and go to WRITE; otherwise go to WAKE.
- WAKE (1 cycle):
  - debug_req_o slice = all ones for every cluster with mask=1 and boot_err=0;
  - load the timeout counter with TimeoutCycles-1;
  - go to WAIT_EOC.
- EOC capture, from WAKE onward: eoc_seen_o[c] sets on eoc_i[c]=1 when mask[c]=1 and boot_err[c]=0. EOC from other clusters is ignored.
- WAIT_EOC:
  - go to DONE when every expected cluster has eoc_seen set, or when no cluster is expected;
  - otherwise, when the counter reaches 0, set timeout_o and go to DONE.
- Expected EOC and timeout in the same cycle: EOC wins; timeout_o stays 0.

## Timing
- Reset values: req_valid_o=0, rsp_ready_o=0, debug_req_o=0, busy_o=0, done_o=0, eoc_seen_o=0, boot_err_o=0, timeout_o=0. State IDLE. req_addr_o and req_data_o are 0.
- Reset mid-operation returns to IDLE immediately. An outstanding request is abandoned.
- All outputs are registered or decoded from state only. No combinational input→output paths.
- Start latency:
  - start_i accepted at edge t → busy_o=1 from t+1;
  - first req_valid_o at t+1+StartDelay.
- Per-cluster write: minimum 2 cycles (WRITE with ready=1, then RESP with rsp_valid=1).
- debug_req_o is high for exactly 1 cycle, the cycle after the last response.
- done_o rises one cycle after the completing EOC sample or after timeout expiry.
- Full timeout: done_o rises TimeoutCycles+1 cycles after WAKE.

## Test plan
- Basic boot:
  - NumClusters=4, mask=4'b1111, entry=32'h8000_3000, ready/rsp always 1;
  - expect writes to 0x4000_0000, 0x4010_0000, 0x4020_0000, 0x4030_0000 with data 0x8000_3000;
  - then one 16-bit all-ones debug_req pulse;
  - eoc_i raised staggered → done_o one cycle after the last EOC, eoc_seen=4'b1111.
- Sparse mask with backpressure:
  - mask=4'b1010, req_ready_i low 5 cycles per request;
  - expect only addresses 0x4010_0000 and 0x4030_0000;
  - req fields stable while stalled;
  - debug_req bits [7:4] and [15:12] only.
- Error skip:
  - rsp_error_i=1 for cluster 2, mask=4'b1111;
  - expect boot_err=4'b0100 and cluster 2 debug_req bits 0;
  - done_o without eoc_i[2].
- Timeout:
  - TimeoutCycles=16, eoc_i[3] never rises;
  - expect timeout_o=1 and done_o 17 cycles after WAKE;
  - eoc_seen=4'b0111.
- Mask zero and restart:
  - mask=0 → done_o one cycle after start, no req_valid_o;
  - a new start from DONE with mask=4'b0001 clears the status flags and re-sequences.
- Reset mid-write:
  - assert rst_ni=0 while req_valid_o=1 → all outputs 0 asynchronously;
  - after release, a new start completes normally.
